// File: rtl/pwm_carrier_gen_if.sv
// Bus bundle for pwm_carrier_gen: mode/period request, load strobe and carrier outputs.
// Optional macro CARRIER_SYNC_EN adds the sync_in/phase_in resync pair.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

interface pwm_carrier_gen_if;
   logic                       enable;
   logic [1:0]                 mode_in;
   logic [`PWMCOUNT_WIDTH-1:0] period_in;
   logic                       maskevent;
`ifdef CARRIER_SYNC_EN
   logic                       sync_in;
   logic [`PWMCOUNT_WIDTH-1:0] phase_in;
`endif
   logic [`PWMCOUNT_WIDTH-1:0] carrier;
   logic [`PWMCOUNT_WIDTH-1:0] period;
   logic                       dir;
   logic                       zero_evt;
   logic                       top_evt;

`ifdef CARRIER_SYNC_EN
   modport master (output enable, mode_in, period_in, maskevent, sync_in, phase_in,
                   input carrier, period, dir, zero_evt, top_evt);
   modport slave (input enable, mode_in, period_in, maskevent, sync_in, phase_in,
                  output carrier, period, dir, zero_evt, top_evt);
`else
   modport master (output enable, mode_in, period_in, maskevent,
                   input carrier, period, dir, zero_evt, top_evt);
   modport slave (input enable, mode_in, period_in, maskevent,
                  output carrier, period, dir, zero_evt, top_evt);
`endif
endinterface

// File: rtl/pwm_carrier_gen.sv
// PWM carrier generator: STOP/UP/DOWN/UPDOWN counter with shadowed mode/period and
// registered zero/top events aligned to the carrier value they describe.
// Optional macro CARRIER_SYNC_EN enables phase resync via sync_in/phase_in.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

module pwm_carrier_gen (
   input logic              clk_i,
   input logic              rst_ni,
   pwm_carrier_gen_if.slave bus_io
);
   localparam int unsigned W = `PWMCOUNT_WIDTH;

   typedef enum logic [1:0] {ModeStop = 2'd0, ModeUp = 2'd1, ModeDown = 2'd2,
                             ModeUpDown = 2'd3} mode_e;

   mode_e          mode_q, mode_d;
   logic [W-1:0]   period_q, period_d;
   logic [W-1:0]   carrier_q, carrier_d;
   logic           dir_q, dir_d;
   logic           zero_evt_q, top_evt_q;
   logic           sync;
   logic [W-1:0]   phase;

`ifdef CARRIER_SYNC_EN
   assign sync  = bus_io.sync_in;
   assign phase = bus_io.phase_in;
`else
   assign sync  = 1'b0;
   assign phase = '0;
`endif

   // Shadow load: a mask event or a disabled counter applies the requested mode/period.
   always_comb begin
      mode_d   = mode_q;
      period_d = period_q;
      if (bus_io.maskevent || !bus_io.enable) begin
         mode_d   = mode_e'(bus_io.mode_in);
         period_d = bus_io.period_in;
      end
   end

   // Count step, always against the period already in effect (a same-edge load lands later).
   always_comb begin
      carrier_d = carrier_q;
      dir_d     = dir_q;
      if (sync) begin
         carrier_d = (phase > period_q) ? period_q : phase;
         dir_d     = 1'b0;
      end else if (period_q == '0) begin
         // Degenerate period pins the carrier at 0; also keeps period_q-1 below from wrapping.
         carrier_d = '0;
      end else if (bus_io.enable) begin
         case (mode_q)
            ModeUp: begin
               dir_d     = 1'b0;
               carrier_d = (carrier_q >= period_q) ? '0 : carrier_q + 1'b1;
            end
            ModeDown: begin
               dir_d     = 1'b1;
               carrier_d = (carrier_q == '0 || carrier_q > period_q) ? period_q
                                                                      : carrier_q - 1'b1;
            end
            ModeUpDown: begin
               if (!dir_q) begin
                  // >= also catches a carrier stranded above a freshly shrunk period.
                  if (carrier_q >= period_q) begin
                     carrier_d = period_q - 1'b1;
                     dir_d     = 1'b1;
                  end else begin
                     carrier_d = carrier_q + 1'b1;
                  end
               end else if (carrier_q == '0) begin
                  carrier_d = W'(1);
                  dir_d     = 1'b0;
               end else begin
                  carrier_d = carrier_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // State and events; events use next-state values so they line up with the carrier.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q     <= ModeStop;
         period_q   <= '0;
         carrier_q  <= '0;
         dir_q      <= 1'b0;
         zero_evt_q <= 1'b1;
         top_evt_q  <= 1'b1;
      end else begin
         mode_q     <= mode_d;
         period_q   <= period_d;
         carrier_q  <= carrier_d;
         dir_q      <= dir_d;
         zero_evt_q <= (carrier_d == '0);
         top_evt_q  <= (carrier_d == period_d);
      end
   end

   assign bus_io.carrier  = carrier_q;
   assign bus_io.period   = period_q;
   assign bus_io.dir      = dir_q;
   assign bus_io.zero_evt = zero_evt_q;
   assign bus_io.top_evt  = top_evt_q;
endmodule

// File: tb/tb_pwm_carrier_gen.sv
// Self-checking bench for pwm_carrier_gen: directed sequences with literal expectations
// plus a per-cycle comparison against a behavioural carrier model.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

module tb_pwm_carrier_gen;
   localparam int MStop = 0, MUp = 1, MDown = 2, MUpDown = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   total = 0;
   int   bad = 0;

   pwm_carrier_gen_if bus ();

   pwm_carrier_gen dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model: integer arithmetic, so any modulo wrap in the DUT shows up.
   int m_c, m_p, m_mode;
   int m_dir;

   always @(posedge clk or negedge rst_n) begin : model
      int c, d, ph;
      bit s;
      if (!rst_n) begin
         m_c <= 0; m_p <= 0; m_mode <= MStop; m_dir <= 0;
      end else begin
         c = m_c; d = m_dir; s = 1'b0; ph = 0;
`ifdef CARRIER_SYNC_EN
         s = bus.sync_in; ph = int'(bus.phase_in);
`endif
         if (s) begin
            c = (ph < m_p) ? ph : m_p;
            d = 0;
         end else if (m_p == 0) begin
            c = 0;
         end else if (bus.enable) begin
            if (m_mode == MUp) begin
               d = 0;
               c = (c >= m_p) ? 0 : c + 1;
            end else if (m_mode == MDown) begin
               d = 1;
               c = (c == 0 || c > m_p) ? m_p : c - 1;
            end else if (m_mode == MUpDown) begin
               if (d == 0 && c >= m_p) begin c = m_p - 1; d = 1; end
               else if (d == 0) c = c + 1;
               else if (c == 0) begin c = 1; d = 0; end
               else c = c - 1;
            end
         end
         m_c   <= c;
         m_dir <= d;
         if (bus.maskevent || !bus.enable) begin
            m_mode <= int'(bus.mode_in);
            m_p    <= int'(bus.period_in);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Per-cycle comparison against the model while out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("model carrier", 32'(bus.carrier), 32'(m_c));
         chk("model period", 32'(bus.period), 32'(m_p));
         chk("model dir", 32'(bus.dir), 32'(m_dir));
         chk("model zero_evt", 32'(bus.zero_evt), 32'(m_c == 0));
         chk("model top_evt", 32'(bus.top_evt), 32'(m_c == m_p));
      end
   end

   task automatic tick_chk(input string nm, input int c, input int d);
      @(negedge clk);
      chk({nm, " carrier"}, 32'(bus.carrier), 32'(c));
      chk({nm, " dir"}, 32'(bus.dir), 32'(d));
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, " carrier"}, 32'(bus.carrier), 32'd0);
      chk({nm, " period"}, 32'(bus.period), 32'd0);
      chk({nm, " dir"}, 32'(bus.dir), 32'd0);
      chk({nm, " zero_evt"}, 32'(bus.zero_evt), 32'd1);
      chk({nm, " top_evt"}, 32'(bus.top_evt), 32'd1);
   endtask

   // Reset, then one maskevent load; returns just after the load edge (carrier 0).
   task automatic restart(input int mode, input int per);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n         = 1'b1;
      bus.enable    = 1'b1;
      bus.mode_in   = 2'(mode);
      bus.period_in = `PWMCOUNT_WIDTH'(per);
      bus.maskevent = 1'b1;
      @(negedge clk);
      bus.maskevent = 1'b0;
      chk("restart carrier", 32'(bus.carrier), 32'd0);
      chk("restart period", 32'(bus.period), 32'(per));
   endtask

   initial begin
      bus.enable    = 1'b1;
      bus.mode_in   = 2'd0;
      bus.period_in = '0;
      bus.maskevent = 1'b0;
`ifdef CARRIER_SYNC_EN
      bus.sync_in  = 1'b0;
      bus.phase_in = '0;
`endif
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk_reset_vals("reset");

      // UP, period 4: 0,1,2,3,4,0,1 with top on 4 and zero on 0.
      restart(MUp, 4);
      chk("up zero at 0", 32'(bus.zero_evt), 32'd1);
      tick_chk("up1", 1, 0);
      tick_chk("up2", 2, 0);
      tick_chk("up3", 3, 0);
      tick_chk("up4", 4, 0);
      chk("up top at 4", 32'(bus.top_evt), 32'd1);
      chk("up no zero at 4", 32'(bus.zero_evt), 32'd0);
      tick_chk("up wrap", 0, 0);
      chk("up zero at wrap", 32'(bus.zero_evt), 32'd1);
      tick_chk("up again", 1, 0);
      bus.enable = 1'b0;
      tick_chk("hold1", 1, 0);
      tick_chk("hold2", 1, 0);
      bus.enable = 1'b1;
      tick_chk("resume", 2, 0);

      // UPDOWN, period 3.
      restart(MUpDown, 3);
      tick_chk("ud1", 1, 0);
      tick_chk("ud2", 2, 0);
      tick_chk("ud3", 3, 0);
      chk("ud top", 32'(bus.top_evt), 32'd1);
      tick_chk("ud4", 2, 1);
      tick_chk("ud5", 1, 1);
      tick_chk("ud6", 0, 1);
      tick_chk("ud7", 1, 0);
      tick_chk("ud8", 2, 0);

      // UPDOWN, period 1.
      restart(MUpDown, 1);
      tick_chk("ud1a", 1, 0);
      tick_chk("ud1b", 0, 1);
      tick_chk("ud1c", 1, 0);
      tick_chk("ud1d", 0, 1);
      tick_chk("ud1e", 1, 0);

      // UP, period 10 shrunk to 5 at carrier 7: old period used for one more step.
      restart(MUp, 10);
      repeat (6) @(negedge clk);
      tick_chk("shrink pre", 7, 0);
      bus.period_in = 16'd5;
      bus.maskevent = 1'b1;
      tick_chk("shrink step", 8, 0);
      chk("shrink period", 32'(bus.period), 32'd5);
      bus.maskevent = 1'b0;
      tick_chk("shrink wrap", 0, 0);
      tick_chk("shrink next", 1, 0);

      // UPDOWN above a newly smaller period turns around.
      restart(MUpDown, 10);
      repeat (8) @(negedge clk);
      bus.period_in = 16'd5;
      bus.maskevent = 1'b1;
      tick_chk("ud shrink step", 9, 0);
      bus.maskevent = 1'b0;
      tick_chk("ud shrink turn", 4, 1);
      tick_chk("ud shrink down", 3, 1);

      // DOWN then period 0: stuck at 0 with both events.
      restart(MDown, 3);
      tick_chk("dn1", 3, 1);
      tick_chk("dn2", 2, 1);
      bus.period_in = 16'd0;
      bus.maskevent = 1'b1;
      tick_chk("dn3", 1, 1);
      bus.maskevent = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick_chk("p0", 0, 1);
         chk("p0 zero_evt", 32'(bus.zero_evt), 32'd1);
         chk("p0 top_evt", 32'(bus.top_evt), 32'd1);
      end

      // Full-range period: no overflow at the top.
      restart(MDown, 65535);
      tick_chk("ff1", 65535, 1);
      tick_chk("ff2", 65534, 1);
      bus.mode_in   = 2'(MUp);
      bus.maskevent = 1'b1;
      tick_chk("ff3", 65533, 1);
      bus.maskevent = 1'b0;
      tick_chk("ff4", 65534, 0);
      tick_chk("ff5", 65535, 0);
      chk("ff top", 32'(bus.top_evt), 32'd1);
      tick_chk("ff wrap", 0, 0);
      tick_chk("ff6", 1, 0);

`ifdef CARRIER_SYNC_EN
      restart(MUp, 100);
      tick_chk("sync pre", 1, 0);
      bus.sync_in  = 1'b1;
      bus.phase_in = 16'd150;
      tick_chk("sync clamp", 100, 0);
      bus.sync_in  = 1'b0;
      tick_chk("sync wrap", 0, 0);
`endif

      // Reset mid-UPDOWN at carrier 50 going down: outputs clear before the next edge.
      restart(MUpDown, 60);
      repeat (69) @(negedge clk);
      tick_chk("pre reset", 50, 1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async reset");
      @(negedge clk);
      chk_reset_vals("held reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
